// File: rtl/unswap_pkg.sv
// rtl/unswap_pkg.sv - shared lane geometry, FSM states and inverse-map index helper
package unswap_pkg;

    localparam int LANE_W       = 25;
    localparam int GRID         = 5;
    localparam int CENTER_OFS   = 3;
    localparam int RECENTER_OFS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Destination bit index in the restored slice for source bit p.
    function automatic int inv_dest(input int p);
        int nx;
        int ny;
        int yp;
        int xp;
        nx = p % GRID;
        ny = p / GRID;
        yp = (nx + CENTER_OFS) % GRID;
        xp = (3 * ((ny + CENTER_OFS) % GRID) + yp) % GRID;
        return GRID * ((yp + RECENTER_OFS) % GRID) + ((xp + RECENTER_OFS) % GRID);
    endfunction

endpackage

// File: rtl/unswap_map.sv
// rtl/unswap_map.sv - combinational inverse swap permutation of one 5x5 slice
module unswap_map
    import unswap_pkg::*;
(
    input  logic [LANE_W-1:0] in_slice,
    output logic [LANE_W-1:0] out_slice
);

    for (genvar p = 0; p < LANE_W; p++) begin : g_bit
        localparam int DEST = inv_dest(p);
        assign out_slice[DEST] = in_slice[p];
    end

endmodule

// File: rtl/unswap.sv
// rtl/unswap.sv - framed slice un-swapper with per-frame mode latch and one-deep output register
module unswap
    import unswap_pkg::*;
#(
    parameter int SLICES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_slice,
    input  logic              inv_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_slice,
    output logic              out_last,
    output logic              frame_done
);

    localparam int               CNT_W    = $clog2(SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   slice_cnt;
    logic               mode_q;
    logic               accept;
    logic               mode;
    logic               is_last;
    logic [LANE_W-1:0]  mapped;
    logic [LANE_W-1:0]  next_slice;

    unswap_map u_map (
        .in_slice  (in_slice),
        .out_slice (mapped)
    );

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    // The first slice of a frame takes its mode straight from inv_en.
    assign mode       = (state == IDLE) ? inv_en : mode_q;
    assign is_last    = (state == BUSY) && (slice_cnt == LAST_CNT);
    assign next_slice = mode ? mapped : in_slice;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            slice_cnt  <= '0;
            mode_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_slice  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (accept) begin
                out_valid <= 1'b1;
                out_slice <= next_slice;
                out_last  <= is_last;
                if (state == IDLE) begin
                    mode_q    <= inv_en;
                    slice_cnt <= ONE_CNT;
                    state     <= BUSY;
                end else if (is_last) begin
                    slice_cnt <= '0;
                    state     <= IDLE;
                end else begin
                    slice_cnt <= slice_cnt + ONE_CNT;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_unswap.sv
// tb/tb_unswap.sv - randomized scoreboard bench for unswap at SLICES=64 and SLICES=2
module tb_unswap;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_slice = '0;
    logic        inv_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] out_slice;
    logic        out_last;
    logic        frame_done;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [24:0] b_in_slice = '0;
    logic        b_out_valid;
    logic [24:0] b_out_slice;
    logic        b_out_last;
    logic        b_frame_done;

    always #5 clk = ~clk;

    unswap #(.SLICES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_slice(in_slice), .inv_en(inv_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_slice(out_slice), .out_last(out_last),
        .frame_done(frame_done)
    );

    unswap #(.SLICES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_slice(b_in_slice), .inv_en(1'b0), .out_valid(b_out_valid),
        .out_ready(1'b1), .out_slice(b_out_slice), .out_last(b_out_last),
        .frame_done(b_frame_done)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position arithmetic straight from the coordinate rules.
    function automatic int dst(input int p);
        int x1;
        int y1;
        y1 = (p % 5 + 3) % 5;
        x1 = (3 * ((p / 5 + 3) % 5) + y1) % 5;
        return 5 * ((y1 + 2) % 5) + (x1 + 2) % 5;
    endfunction

    function automatic logic [24:0] inv_m(input logic [24:0] s);
        logic [24:0] r;
        r = '0;
        for (int p = 0; p < 25; p++) r[dst(p)] = s[p];
        return r;
    endfunction

    function automatic logic [24:0] fwd_m(input logic [24:0] s);
        logic [24:0] r;
        r = '0;
        for (int p = 0; p < 25; p++) r[p] = s[dst(p)];
        return r;
    endfunction

    typedef struct {
        logic [24:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [24:0] rt_q[$];
    logic [24:0] cur_orig = '0;
    int          pos = 0;
    logic        mode_m = 1'b0;
    logic        exp_done = 1'b0;
    int          ndone = 0;
    bit          mon_on = 0;
    bit          rt_on = 0;
    bit          bp_on = 0;
    bit          prev_stall = 0;
    logic [24:0] prev_slice = '0;
    logic        prev_last = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        #1;
        if (bp_on) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else       out_ready = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            exp_t e;
            chk("in_ready", in_ready, (q.size() == 0) || out_ready);
            chk("out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() != 0) begin
                chk("out_slice", out_slice, q[0].data);
                chk("out_last", out_last, q[0].last);
            end
            chk("frame_done", frame_done, exp_done);
            if (prev_stall) begin
                chk("hold_slice", out_slice, prev_slice);
                chk("hold_last", out_last, prev_last);
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_slice = out_slice;
            prev_last  = out_last;
            if (!rst_n) begin
                q.delete();
                rt_q.delete();
                pos = 0;
                exp_done = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (out_valid && out_ready && q.size() != 0) begin
                    exp_done = q[0].last;
                    if (q[0].last) ndone++;
                    if (rt_on && rt_q.size() != 0) chk("roundtrip", out_slice, rt_q.pop_front());
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    if (pos == 0) mode_m = inv_en;
                    e.data = mode_m ? inv_m(in_slice) : in_slice;
                    e.last = (pos == N - 1);
                    q.push_back(e);
                    if (rt_on) rt_q.push_back(cur_orig);
                    pos = (pos == N - 1) ? 0 : pos + 1;
                end
            end
        end
    end

    int   bcnt = 0;
    int   bdone = 0;
    logic b_exp = 1'b0;

    always @(negedge clk) begin
        if (mon_on && rst_n) begin
            chk("b_frame_done", b_frame_done, b_exp);
            if (b_frame_done) bdone++;
            b_exp = b_out_valid && b_out_last;
            if (b_out_valid) begin
                chk("b_out_slice", b_out_slice, bcnt);
                chk("b_out_last", b_out_last, bcnt % 2 == 1);
                bcnt++;
            end
        end
    end

    task automatic send(input logic [24:0] s, input logic inv);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_slice = s;
        inv_en   = inv;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [24:0] s;
        int          d0;

        @(posedge clk);
        #1;
        mon_on = 1;
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_slice", out_slice, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(25'h1 << 10, 1'b1);
        chk("dir_bit10", out_slice, 25'h1);
        send(25'h1 << 20, 1'b0);
        chk("dir_bit20", out_slice, 25'h2);
        send(25'h1 << 12, 1'b0);
        chk("dir_bit12", out_slice, 25'h1 << 12);
        for (int i = 3; i < N; i++) send(25'($urandom), 1'($urandom));
        idle(2);

        rt_on = 1;
        d0 = ndone;
        for (int i = 0; i < N; i++) begin
            s = 25'($urandom);
            cur_orig = s;
            send(fwd_m(s), 1'b1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        rt_on = 0;
        chk("rt_done_count", ndone - d0, 1);
        chk("rt_all_drained", rt_q.size(), 0);

        bp_on = 1;
        for (int i = 0; i < N; i++) send(25'($urandom), 1'($urandom));
        idle(6);
        bp_on = 0;
        idle(2);
        chk("bp_drained", q.size(), 0);

        for (int i = 0; i < N; i++) begin
            s = 25'($urandom);
            send(s, i != 0);
            chk("latch_pass", out_slice, s);
        end
        for (int i = 0; i < N; i++) begin
            s = 25'($urandom);
            send(s, 1'b1);
            chk("latch_inv", out_slice, inv_m(s));
        end
        idle(2);

        for (int i = 0; i < 30; i++) send(25'($urandom), 1'($urandom));
        in_valid = 1'b1;
        in_slice = 25'($urandom);
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        for (int i = 0; i < N; i++) begin
            send(25'($urandom), 1'($urandom));
            chk("rst_last_pos", out_last, i == N - 1);
        end
        idle(3);

        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_in_slice = 25'(i);
            @(negedge clk);
            chk("b_in_ready", b_in_ready, 1);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        idle(3);
        chk("b_out_count", bcnt, 8);
        chk("b_done_count", bdone, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/unswap.md
UNSWAP -- requirements
Module: unswap

Interface
REQ-001 The block SHALL have parameter SLICES, default 64: number of 25-bit slices per frame, at least 2.
REQ-002 Port clk, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset SHALL be synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: in_slice is valid.
REQ-005 Port in_ready, output, 1 bit: the block can accept a slice this cycle.
REQ-006 Port in_slice, input, 25 bits: permuted 5x5 slice, bit p at x=p%5, y=p/5.
REQ-007 Port inv_en, input, 1 bit: 1 selects the inverse mapping, 0 selects pass-through; it SHALL be sampled only on the first slice of a frame.
REQ-008 Port out_valid, output, 1 bit: out_slice is valid.
REQ-009 Port out_ready, input, 1 bit: the downstream side accepts out_slice.
REQ-010 Port out_slice, output, 25 bits: the restored slice.
REQ-011 Port out_last, output, 1 bit: qualifies out_slice as slice SLICES-1 of the frame.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse when the last slice is accepted downstream.

Function
REQ-013 A transfer SHALL occur when valid and ready are both high on a clock edge, on either side.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), so a continuous stream runs at one slice per cycle.
REQ-015 Latency SHALL be 1 cycle: a slice accepted at edge N SHALL appear on out_slice after edge N.
REQ-016 The inverse map SHALL be computed for each source position p as follows:
- nx=p%5, ny=p/5
- y'=(nx+3)%5
- x'=(3*((ny+3)%5)+y')%5
- x=(x'+2)%5, y=(y'+2)%5
- out_slice[5y+x]=in_slice[p]
REQ-017 The inverse map SHALL be an exact inverse of the forward swap permutation; composing the two SHALL give the identity on all 25 bits.
REQ-018 With pass-through selected, out_slice SHALL equal in_slice.
REQ-019 The FSM SHALL have two states, IDLE and BUSY.
REQ-020 In IDLE, the first accepted slice SHALL latch inv_en into mode_q, load slice_cnt=1, and move the FSM to BUSY.
REQ-021 In BUSY, each accepted slice SHALL increment slice_cnt.
REQ-022 In BUSY, the slice for which slice_cnt==SLICES-1 SHALL be tagged last, clear slice_cnt to 0, and return the FSM to IDLE.
REQ-023 The mode for a slice SHALL be taken from inv_en in the same cycle when that slice is first in its frame, and from mode_q otherwise.
REQ-024 A change of inv_en in mid-frame SHALL have no effect until the next frame.
REQ-025 out_last SHALL be registered alongside out_slice and held stable while out_valid && !out_ready.
REQ-026 Under backpressure (out_valid && !out_ready), out_slice, out_last and out_valid SHALL be held stable.
REQ-027 frame_done SHALL pulse for exactly 1 cycle, in the cycle after out_valid && out_ready && out_last.
REQ-028 Simultaneous output drain and input accept SHALL replace the output register with no bubble.
REQ-029 slice_cnt SHALL be $clog2(SLICES) bits wide and SHALL never exceed SLICES-1; wrap-around SHALL be explicit, not by overflow.

Reset
REQ-030 When rst_n=0 at an edge, the block SHALL set:
- out_valid=0, out_last=0, out_slice=0
- frame_done=0, in_ready=1
- slice_cnt=0, mode_q=0, FSM=IDLE
REQ-031 Reset in mid-frame SHALL discard the partial frame.
REQ-032 The first accepted slice after reset SHALL start a new frame.
REQ-033 A slice in flight during reset SHALL be dropped with no out_valid.

Structure
REQ-034 A shared package SHALL hold:
- LANE_W=25, GRID=5, CENTER_OFS=3, RECENTER_OFS=2
- the FSM state enumeration
REQ-035 The inverse map SHALL be a combinational sub-module, unswap_map, with a 25-bit input and a 25-bit output, instantiated once.

Verification
REQ-036 Directed single-bit scenarios, inv_en=1:
- in_slice=25'h1 shifted to bit 10 -> out bit 0 only
- bit 20 -> out bit 1
- bit 12 -> out bit 12 (fixed point)
REQ-037 Round trip: a stream of SLICES=64 random slices, passed through the forward swap and then this block, SHALL reproduce the inputs in order with out_last on slice 63 and one frame_done pulse.
REQ-038 Backpressure: out_ready toggling 1-0-0-1 on a full stream SHALL produce no loss, no duplicate, and outputs held during stalls.
REQ-039 Mode latch: inv_en=0 on slice 0 and toggled to 1 mid-frame SHALL pass the whole frame through unmodified; the next frame with inv_en=1 SHALL be inverted.
REQ-040 Reset at slice 30: rst_n low for 1 cycle SHALL give out_valid=0 and slice_cnt=0; the next frame's out_last SHALL fall exactly 64 slices later.
REQ-041 SLICES=2: back-to-back frames SHALL give out_last on every second slice and a frame_done after each.
